// File: rtl/bcd_pkg.sv
// bcd_pkg: shared widths, FSM state encoding and digit helpers for bcd2bin_seq
package bcd_pkg;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_W = 4;
    localparam int BIN_W = 14;
    localparam int IDX_W = $clog2(BCD_DIGITS);
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t CONV = 2'd1;
    localparam state_t DONE = 2'd2;
    typedef logic [BCD_DIGITS-1:0][BCD_W-1:0] digits_t;
    function automatic logic [IDX_W-1:0] top_digit(digits_t d);
        top_digit = '0;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (d[i] != '0) top_digit = IDX_W'(i);
    endfunction
    function automatic logic any_invalid(digits_t d);
        any_invalid = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (d[i] > BCD_W'(9)) any_invalid = 1'b1;
    endfunction
endpackage

// File: rtl/bcd2bin_seq_if.sv
// bcd2bin_seq_if: input/output handshake bus; err exists only with BCD2BIN_SEQ_BCD_CHECK_EN
interface bcd2bin_seq_if;
    import bcd_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [BCD_W-1:0] bcd3;
    logic [BCD_W-1:0] bcd2;
    logic [BCD_W-1:0] bcd1;
    logic [BCD_W-1:0] bcd0;
    logic out_valid;
    logic out_ready;
    logic [BIN_W-1:0] binary_out;
`ifdef BCD2BIN_SEQ_BCD_CHECK_EN
    logic err;
    modport slave (
        input in_valid, bcd3, bcd2, bcd1, bcd0, out_ready,
        output in_ready, out_valid, binary_out, err
    );
    modport master (
        output in_valid, bcd3, bcd2, bcd1, bcd0, out_ready,
        input in_ready, out_valid, binary_out, err
    );
`else
    modport slave (
        input in_valid, bcd3, bcd2, bcd1, bcd0, out_ready,
        output in_ready, out_valid, binary_out
    );
    modport master (
        output in_valid, bcd3, bcd2, bcd1, bcd0, out_ready,
        input in_ready, out_valid, binary_out
    );
`endif
endinterface

// File: rtl/bcd_mac_step.sv
// bcd_mac_step: combinational acc*10 + digit using shifts, truncated to BIN_W
module bcd_mac_step
    import bcd_pkg::*;
(
    input  logic [BIN_W-1:0] acc_i,
    input  logic [BCD_W-1:0] digit_i,
    output logic [BIN_W-1:0] acc_o
);
    assign acc_o = (acc_i << 3) + (acc_i << 1) + BIN_W'(digit_i);
endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential 4-digit BCD to binary converter; BCD2BIN_SEQ_BCD_CHECK_EN adds invalid-digit err
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int ZERO_SKIP = 0
) (
    input logic clk,
    input logic rst,
    bcd2bin_seq_if.slave bus
);
    state_t state_q, state_d;
    digits_t dig_q, dig_d, dig_in;
    logic [BIN_W-1:0] acc_q, acc_d, bin_q, bin_d, mac;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic bad;
`ifdef BCD2BIN_SEQ_BCD_CHECK_EN
    logic err_q, err_d;
    assign bad = any_invalid(dig_in);
    assign bus.err = err_q;
`else
    assign bad = 1'b0;
`endif
    assign dig_in = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
    assign bus.in_ready = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.binary_out = bin_q;

    bcd_mac_step u_mac (.acc_i(acc_q), .digit_i(dig_q[idx_q]), .acc_o(mac));

    // accept, per-digit accumulate, and hold the result until the output transfer
    always_comb begin
        state_d = state_q;
        dig_d = dig_q;
        acc_d = acc_q;
        idx_d = idx_q;
        bin_d = bin_q;
`ifdef BCD2BIN_SEQ_BCD_CHECK_EN
        err_d = err_q;
`endif
        if (state_q == IDLE && bus.in_valid) begin
            dig_d = dig_in;
            acc_d = '0;
            idx_d = ZERO_SKIP != 0 ? top_digit(dig_in) : IDX_W'(BCD_DIGITS - 1);
            state_d = bad || (ZERO_SKIP != 0 && dig_in == '0) ? DONE : CONV;
            bin_d = state_d == DONE ? '0 : bin_q;
`ifdef BCD2BIN_SEQ_BCD_CHECK_EN
            err_d = bad;
`endif
        end else if (state_q == CONV) begin
            acc_d = mac;
            idx_d = idx_q - 1'b1;
            state_d = idx_q == '0 ? DONE : CONV;
            bin_d = idx_q == '0 ? mac : bin_q;
        end else if (state_q == DONE && bus.out_ready) begin
            state_d = IDLE;
            acc_d = '0;
            idx_d = IDX_W'(BCD_DIGITS - 1);
        end
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dig_q <= '0;
            acc_q <= '0;
            idx_q <= IDX_W'(BCD_DIGITS - 1);
            bin_q <= '0;
        end else begin
            state_q <= state_d;
            dig_q <= dig_d;
            acc_q <= acc_d;
            idx_q <= idx_d;
            bin_q <= bin_d;
        end
    end

`ifdef BCD2BIN_SEQ_BCD_CHECK_EN
    // invalid-digit flag, updated together with binary_out
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else err_q <= err_d;
    end
`endif
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: table, corner-case and randomized checks of bcd2bin_seq for ZERO_SKIP 0 and 1
module tb_bcd2bin_seq;
    import bcd_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd2bin_seq_if ifa ();
    bcd2bin_seq_if ifb ();
    logic iv[2], ordy[2], ir[2], ov[2], er[2];
    logic [15:0] dig[2];
    logic [13:0] bo[2];

    assign ifa.in_valid = iv[0];
    assign ifa.out_ready = ordy[0];
    assign {ifa.bcd3, ifa.bcd2, ifa.bcd1, ifa.bcd0} = dig[0];
    assign ir[0] = ifa.in_ready;
    assign ov[0] = ifa.out_valid;
    assign bo[0] = ifa.binary_out;
    assign ifb.in_valid = iv[1];
    assign ifb.out_ready = ordy[1];
    assign {ifb.bcd3, ifb.bcd2, ifb.bcd1, ifb.bcd0} = dig[1];
    assign ir[1] = ifb.in_ready;
    assign ov[1] = ifb.out_valid;
    assign bo[1] = ifb.binary_out;
`ifdef BCD2BIN_SEQ_BCD_CHECK_EN
    assign er[0] = ifa.err;
    assign er[1] = ifb.err;
`else
    assign er[0] = 1'b0;
    assign er[1] = 1'b0;
`endif

    bcd2bin_seq #(.ZERO_SKIP(0)) dut0 (.clk(clk), .rst(rst), .bus(ifa));
    bcd2bin_seq #(.ZERO_SKIP(1)) dut1 (.clk(clk), .rst(rst), .bus(ifb));

    typedef struct {
        logic [15:0] d;
        int bin;
        int lat0;
        int lat1;
    } vec_t;
    vec_t vt[7];

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input int s, input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL dut%0d %s: got %0d expected %0d", s, nm, act, exp);
        end
    endtask

    function automatic int model(logic [15:0] d);
        int v;
        v = int'(d[15:12]) * 1000 + int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
`ifdef BCD2BIN_SEQ_BCD_CHECK_EN
        if (d[15:12] > 9 || d[11:8] > 9 || d[7:4] > 9 || d[3:0] > 9) return 1 << 16;
`endif
        return v % 16384;
    endfunction

    // one word through DUT s; lat = edges after E0 until out_valid; stall = cycles out_ready held low
    task automatic xfer(input int s, input logic [15:0] d, input int exp_bin, input int exp_err,
                        input int exp_lat, input int stall);
        int n;
        n = 0;
        ordy[s] = 1'b0;
        while (!ir[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(s, "in_ready_wait", int'(n < 50), 1);
        iv[s] = 1'b1;
        dig[s] = d;
        @(negedge clk);
        iv[s] = 1'b0;
        dig[s] = ~d;
        n = 0;
        while (!ov[s] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(s, "latency", n, exp_lat);
        chk(s, "busy_in_ready", ir[s], 0);
        chk(s, "binary_out", bo[s], exp_bin);
        chk(s, "err", er[s], exp_err);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk(s, "stall_valid", ov[s], 1);
            chk(s, "stall_value", bo[s], exp_bin);
            chk(s, "stall_in_ready", ir[s], 0);
        end
        ordy[s] = 1'b1;
        @(negedge clk);
        chk(s, "post_valid", ov[s], 0);
        chk(s, "post_in_ready", ir[s], 1);
        @(negedge clk);
        chk(s, "no_dup", ov[s], 0);
        ordy[s] = 1'b0;
    endtask

    logic [15:0] stim[$];
    int q0[$], q1[$];
    int sent[2], got[2], e, cyc;
    logic pend[2], r;

    initial begin
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0;
            ordy[s] = 1'b0;
            dig[s] = 16'h0;
        end
        vt[0] = '{16'h9999, 9999, 4, 4};
        vt[1] = '{16'h0000, 0, 4, 0};
        vt[2] = '{16'h0042, 42, 4, 2};
        vt[3] = '{16'h0007, 7, 4, 1};
        vt[4] = '{16'h0100, 100, 4, 3};
        vt[5] = '{16'h1000, 1000, 4, 4};
        vt[6] = '{16'h0905, 905, 4, 3};

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk(s, "rst_out_valid", ov[s], 0);
            chk(s, "rst_in_ready", ir[s], 1);
            chk(s, "rst_binary_out", bo[s], 0);
            chk(s, "rst_err", er[s], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            for (int s = 0; s < 2; s++)
                xfer(s, vt[i].d, vt[i].bin, 0, s == 1 ? vt[i].lat1 : vt[i].lat0, 0);

        for (int s = 0; s < 2; s++) xfer(s, 16'h1234, 1234, 0, 4, 10);

`ifdef BCD2BIN_SEQ_BCD_CHECK_EN
        for (int s = 0; s < 2; s++) xfer(s, 16'h1A00, 0, 1, 0, 0);
`else
        for (int s = 0; s < 2; s++) xfer(s, 16'h1A00, 2000, 0, 4, 0);
`endif

        iv[0] = 1'b1;
        dig[0] = 16'h5678;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk(0, "conv_rst_valid", ov[0], 0);
        chk(0, "conv_rst_in_ready", ir[0], 1);
        chk(0, "conv_rst_binary_out", bo[0], 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk(0, "conv_rst_no_ghost", ov[0], 0);
        end
        xfer(0, 16'h0042, 42, 0, 4, 0);

        iv[1] = 1'b1;
        dig[1] = 16'h0000;
        @(negedge clk);
        iv[1] = 1'b0;
        chk(1, "zero_done", ov[1], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk(1, "done_rst_valid", ov[1], 0);
        chk(1, "done_rst_in_ready", ir[1], 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk(1, "done_rst_no_ghost", ov[1], 0);
        end

        for (int v = 0; v <= 9999; v += 3)
            stim.push_back({4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)});
        for (int i = 0; i < 200; i++) begin
            e = int'($urandom_range(0, 9999));
            stim.push_back({4'(e / 1000), 4'((e / 100) % 10), 4'((e / 10) % 10), 4'(e % 10)});
        end
        for (int i = 0; i < 40; i++) stim.push_back(16'($urandom_range(0, 65535)));

        for (int s = 0; s < 2; s++) begin
            sent[s] = 0;
            got[s] = 0;
            pend[s] = 1'b0;
        end
        cyc = 0;
        while ((got[0] < stim.size() || got[1] < stim.size()) && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            for (int s = 0; s < 2; s++) begin
                if (pend[s]) begin
                    iv[s] = 1'b0;
                    pend[s] = 1'b0;
                end
                if (!iv[s] && sent[s] < stim.size()) begin
                    dig[s] = stim[sent[s]];
                    iv[s] = 1'b1;
                end
                if (iv[s] && ir[s]) begin
                    if (s == 0) q0.push_back(model(dig[s]));
                    else q1.push_back(model(dig[s]));
                    sent[s]++;
                    pend[s] = 1'b1;
                end
                r = $urandom_range(0, 3) != 0;
                ordy[s] = r;
                if (ov[s] && r) begin
                    if ((s == 0 ? q0.size() : q1.size()) == 0) begin
                        chk(s, "sweep_extra_transfer", 1, 0);
                    end else begin
                        e = s == 0 ? q0.pop_front() : q1.pop_front();
                        chk(s, "sweep_binary_out", bo[s], e & 16'hFFFF);
                        chk(s, "sweep_err", er[s], e >> 16);
                    end
                    got[s]++;
                end
            end
        end
        for (int s = 0; s < 2; s++) begin
            chk(s, "sweep_sent", sent[s], stim.size());
            chk(s, "sweep_received", got[s], stim.size());
        end
        chk(0, "sweep_queue_left", q0.size(), 0);
        chk(1, "sweep_queue_left", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 Parameter: ZERO_SKIP, default 0, when 1 skips leading zero digits to shorten latency.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream presents a 4-digit BCD word.
REQ-005 in_ready  output  1  block accepts the word; asserted iff state IDLE.
REQ-006 bcd3, bcd2, bcd1, bcd0  input  4 each  BCD digits; bcd3 is most significant.
REQ-007 out_valid  output  1  binary_out (and err) hold a result.
REQ-008 out_ready  input  1  downstream accepts the result.
REQ-009 binary_out  output  14  unsigned binary value, range 0..9999.
REQ-010 err  output  1  invalid-digit flag; port present only under BCD_CHECK_EN.

Function
REQ-011 States SHALL be IDLE, CONV and DONE.
REQ-012 Accept edge E0 = rising edge with in_valid && in_ready; digits SHALL be captured at E0, and later input changes SHALL be ignored.
REQ-013 In CONV, each edge SHALL compute acc = acc*10 + digit[idx], with acc*10 formed as (acc<<3)+(acc<<1), then decrement idx; at idx==0 the next state SHALL be DONE.
REQ-014 ZERO_SKIP=0: idx SHALL start at 3 with acc=0; out_valid SHALL be high after edge E0+4.
REQ-015 ZERO_SKIP=1: idx SHALL start at the highest nonzero digit k; out_valid SHALL be high after edge E0+(k+1).
REQ-016 ZERO_SKIP=1, all digits zero: the block SHALL go IDLE->DONE at E0 with binary_out=0; out_valid SHALL be high after E0.
REQ-017 In DONE, out_valid=1, and binary_out/err SHALL stay stable until out_valid && out_ready is seen at an edge; the block SHALL then return to IDLE.
REQ-018 While not IDLE, in_ready SHALL be 0; no overlap or bypass; in_ready SHALL return to 1 in the cycle after the output transfer.
REQ-019 binary_out SHALL change only on entry to DONE, never during CONV.
REQ-020 Arithmetic SHALL be 14-bit unsigned; any overflow SHALL truncate mod 2^14, which is reachable only with non-BCD digits.

Reset
REQ-021 When rst=1 at an edge, the block SHALL go to IDLE with out_valid=0, binary_out=0, err=0, acc=0 and idx=3; rst SHALL take priority over all handshakes.
REQ-022 Reset during CONV or DONE SHALL discard the in-flight word, and no out_valid pulse SHALL follow.

Configuration
REQ-023 Macro BCD2BIN_SEQ_BCD_CHECK_EN: when defined, a digit >9 at E0 SHALL send the block directly to DONE with err=1 and binary_out=0; the error check SHALL precede zero-skip; err SHALL be 0 for valid words.
REQ-024 Without BCD2BIN_SEQ_BCD_CHECK_EN, the err port SHALL be absent and digits >9 SHALL be used as-is in REQ-013 arithmetic.

Structure
REQ-025 Shared package bcd_pkg SHALL hold BCD_DIGITS=4, BIN_W=14, BCD_W=4 and the state typedef (IDLE/CONV/DONE).
REQ-026 Sub-module bcd_mac_step SHALL be combinational and compute acc*10+digit at BIN_W width; it SHALL be instantiated once.

Verification
REQ-027 Digits 9,9,9,9 with ZERO_SKIP=0 and out_ready=1 -> out_valid after E0+4; binary_out=9999 (14'h270F); in_ready=1 the following cycle.
REQ-028 Digits 0,0,0,0 with ZERO_SKIP=1 -> out_valid after E0; binary_out=0. Digits 0,0,4,2 -> out_valid after E0+2; binary_out=42.
REQ-029 Digits 1,2,3,4 with out_ready=0 for 10 cycles -> out_valid=1, binary_out=1234 stable, in_ready=0 throughout; release -> exactly one transfer.
REQ-030 Digits 1,A,0,0 -> with the macro: err=1, binary_out=0 after E0; without the macro: binary_out=2000 after E0+4.
REQ-031 Digits 5,6,7,8 with rst at the second CONV edge -> IDLE next cycle with out_valid=0; then 0,0,4,2 -> 42.
REQ-032 Exhaustive sweep 0..9999 with random out_ready stalls, both ZERO_SKIP values -> every binary_out matches the decimal value and no transfer is lost or duplicated.
